// File: rtl/sbox_state_reg.sv
// Single-entry output buffer for the masked S-box layer. Optionally refreshes
// the four shares with three fresh masks while loading.
module sbox_state_reg #(
    parameter int unsigned W = 160
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   y1,
    input  logic [W-1:0]   y2,
    input  logic [W-1:0]   y3,
    input  logic [W-1:0]   y4,
    input  logic [3*W-1:0] rnd,
    input  logic           refresh_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   q1,
    output logic [W-1:0]   q2,
    output logic [W-1:0]   q3,
    output logic [W-1:0]   q4,
    output logic [7:0]     xfer_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic         accept, consume;
    logic [W-1:0] m1, m2, m3;
    logic [W-1:0] q1_q, q2_q, q3_q, q4_q;
    logic [W-1:0] q1_d, q2_d, q3_d, q4_d;
    logic [7:0]   cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (consume && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output logic; in_ready reads 1 during reset because state_q is EMPTY
    always_comb begin
        in_ready  = (state_q == EMPTY) || out_ready;
        out_valid = (state_q == FULL);
    end

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Masks are zeroed rather than muxing the shares so every share keeps one path.
    always_comb begin
        m1   = refresh_en ? rnd[W-1:0]     : '0;
        m2   = refresh_en ? rnd[2*W-1:W]   : '0;
        m3   = refresh_en ? rnd[3*W-1:2*W] : '0;
        q1_d = y1 ^ m1;
        q2_d = y2 ^ m2;
        q3_d = y3 ^ m3;
        q4_d = y4 ^ m1 ^ m2 ^ m3;
        cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q  <= '0;
            q2_q  <= '0;
            q3_q  <= '0;
            q4_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            q1_q  <= q1_d;
            q2_q  <= q2_d;
            q3_q  <= q3_d;
            q4_q  <= q4_d;
            cnt_q <= cnt_d;
        end
    end

    assign q1       = q1_q;
    assign q2       = q2_q;
    assign q3       = q3_q;
    assign q4       = q4_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_sbox_state_reg.sv
// Bench for sbox_state_reg: directed steps plus randomized traffic against a
// transaction-level model of the buffer.
module tb_sbox_state_reg;

    localparam int unsigned W = 160;
    typedef logic [3*W-1:0] wide_t;
    localparam logic [W-1:0] P5 = {(W/4){4'h5}};
    localparam logic [W-1:0] PA = {(W/4){4'hA}};

    logic           clk, rst_n, in_valid, in_ready, refresh_en, out_valid, out_ready;
    logic [W-1:0]   y1, y2, y3, y4, q1, q2, q3, q4;
    logic [3*W-1:0] rnd;
    logic [7:0]     xfer_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: whether an entry is held, its expected shares, transfer count
    bit           m_full;
    logic [W-1:0] e1, e2, e3, e4;
    int unsigned  m_cnt;

    sbox_state_reg #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .rnd(rnd), .refresh_en(refresh_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .q1(q1), .q2(q2), .q3(q3), .q4(q4), .xfer_cnt(xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic drive(input bit iv, input bit ordy, input bit ren,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic [3*W-1:0] r);
        in_valid = iv; out_ready = ordy; refresh_en = ren;
        y1 = a; y2 = b; y3 = c; y4 = d; rnd = r;
    endtask

    task automatic drive_rand(input bit iv, input bit ordy);
        drive(iv, ordy, 1'($urandom_range(0, 1)), rand_w(), rand_w(), rand_w(), rand_w(),
              {rand_w(), rand_w(), rand_w()});
    endtask

    task automatic model_reset();
        m_full = 0; e1 = '0; e2 = '0; e3 = '0; e4 = '0; m_cnt = 0;
    endtask

    // Applies the buffer's rules for the upcoming edge using the current inputs.
    task automatic model_edge();
        logic [W-1:0] a, b, c;
        bit acc;
        if (!rst_n) return;
        acc = in_valid && (!m_full || out_ready);
        if (acc) begin
            a = refresh_en ? rnd[W-1:0]     : '0;
            b = refresh_en ? rnd[2*W-1:W]   : '0;
            c = refresh_en ? rnd[3*W-1:2*W] : '0;
            e1 = y1 ^ a; e2 = y2 ^ b; e3 = y3 ^ c; e4 = y4 ^ a ^ b ^ c;
            m_full = 1;
            m_cnt  = (m_cnt + 1) % 256;
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag);
        #1;
        chk({tag, ".in_ready"}, wide_t'(in_ready), wide_t'(!m_full || out_ready));
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, wide_t'(out_valid), wide_t'(m_full));
        chk({tag, ".q1"}, wide_t'(q1), wide_t'(e1));
        chk({tag, ".q2"}, wide_t'(q2), wide_t'(e2));
        chk({tag, ".q3"}, wide_t'(q3), wide_t'(e3));
        chk({tag, ".q4"}, wide_t'(q4), wide_t'(e4));
        chk({tag, ".xfer_cnt"}, wide_t'(xfer_cnt), wide_t'(m_cnt));
    endtask

    initial begin
        logic [W-1:0] ha1, ha2, ha3, ha4, yx;

        rst_n = 1'b0;
        drive(0, 0, 0, '0, '0, '0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.in_ready", wide_t'(in_ready), wide_t'(1));
        rst_n = 1'b1;

        // Plain load
        drive(1, 0, 0, W'(1), W'(2), W'(4), W'(8), {rand_w(), rand_w(), rand_w()});
        chk_ready("plain");
        tick();
        check_all("plain");
        chk("plain.q1c", wide_t'(q1), wide_t'(1));
        chk("plain.q4c", wide_t'(q4), wide_t'(8));
        chk("plain.cntc", wide_t'(xfer_cnt), wide_t'(1));

        // Drain
        drive_rand(0, 1);
        tick();
        check_all("drain");
        chk("drain.q2c", wide_t'(q2), wide_t'(2));

        // Refresh with fixed masks
        drive(1, 0, 1, '0, '0, '0, '0, {W'(0), P5, {W{1'b1}}});
        tick();
        check_all("refresh");
        chk("refresh.q1c", wide_t'(q1), wide_t'({W{1'b1}}));
        chk("refresh.q2c", wide_t'(q2), wide_t'(P5));
        chk("refresh.q3c", wide_t'(q3), wide_t'(0));
        chk("refresh.q4c", wide_t'(q4), wide_t'(PA));
        chk("refresh.xor", wide_t'(q1 ^ q2 ^ q3 ^ q4), wide_t'(0));

        // Backpressure: hold A while B waits, then swap on the consuming edge
        drive_rand(0, 1);
        tick();
        drive_rand(1, 0);
        tick();
        ha1 = e1; ha2 = e2; ha3 = e3; ha4 = e4;
        check_all("bp_load");
        drive_rand(1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp.in_ready", wide_t'(in_ready), wide_t'(0));
            tick();
            chk("bp.out_valid", wide_t'(out_valid), wide_t'(1));
            chk("bp.hold", wide_t'({q4, q3, q2} ^ {ha4, ha3, ha2}) | wide_t'(q1 ^ ha1), wide_t'(0));
        end
        out_ready = 1'b1;
        chk_ready("bp_release");
        tick();
        check_all("bp_release");
        chk("bp_release.ov", wide_t'(out_valid), wide_t'(1));

        // Asynchronous reset while FULL and stalled
        drive_rand(1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.in_ready", wide_t'(in_ready), wide_t'(1));
        tick();
        check_all("in_rst");
        rst_n = 1'b1;
        drive_rand(1, 0);
        chk_ready("first_after_rst");
        tick();
        check_all("first_after_rst");
        chk("first_after_rst.cntc", wide_t'(xfer_cnt), wide_t'(1));

        // Streaming from a fresh reset: 300 back-to-back transfers
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            drive_rand(1, 1);
            yx = y1 ^ y2 ^ y3 ^ y4;
            chk_ready("stream");
            tick();
            chk("stream.xor", wide_t'(q1 ^ q2 ^ q3 ^ q4), wide_t'(yx));
            check_all("stream");
            if (i == 256) chk("stream.wrap", wide_t'(xfer_cnt), wide_t'(0));
        end
        chk("stream.cnt300", wide_t'(xfer_cnt), wide_t'(44));

        // Random handshake traffic
        for (int i = 0; i < 200; i++) begin
            drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_ready("rand");
            tick();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
